cp2_exec: RTL and testbench

//   EX-stage end of the coprocessor-2 (CP2) command path. Consumes the registered CP2 command
//   (fs/ts/as strobes, write data, instruction-enable) from the ID/EX pipeline register.

---
 rtl/cp2_exec.sv | 210 +++++++++++++++++++++
 tb/tb_cp2_exec.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp2_exec.sv
// cp2_exec: EX-stage end of the coprocessor-2 command path.
// Executes the registered ts/fs/as command on an 8-entry register file.
// A MUL runs as a shift-add sequence and stalls the pipeline through cp2_busy.
module cp2_exec #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_en,
  input  logic              id_cp2_ts_0,
  input  logic              id_cp2_fs_0,
  input  logic              id_cp2_as_0,
  input  logic [DATA_W-1:0] id_cp2_wr_data,
  input  logic              cp_irenable_0,
  input  logic [31:0]       cp2_insn,
  output logic              cp2_busy,
  output logic [DATA_W-1:0] cp2_rd_data,
  output logic              cp2_rd_valid,
  output logic              cp2_mul_done,
  output logic              cp2_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_MUL = 3'd2;
  localparam logic [2:0] FN_AND = 3'd3;
  localparam logic [2:0] FN_OR  = 3'd4;
  localparam logic [2:0] FN_XOR = 3'd5;
  localparam logic [2:0] FN_SLL = 3'd6;
  localparam logic [2:0] FN_SRL = 3'd7;

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   regs_r [NREG];
  logic [31:0]         ir_r;
  logic [DATA_W-1:0]   mcand_r, mplier_r, acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [REG_AW-1:0]   mul_rd_r;
  logic                rd_valid_r, mul_done_r, err_r;
  logic [DATA_W-1:0]   rd_data_r;

  logic [31:0]         dec_insn_s;
  logic [REG_AW-1:0]   rd_s, rs_s, rt_s;
  logic [2:0]          func_s;
  logic                accept_s, do_ts_s, do_as_s, do_fs_s, err_s, start_mul_s;
  logic [DATA_W-1:0]   op_a_s, op_b_s, alu_s;
  logic [4:0]          shamt_s;
  logic                unused_dec_s;

  // Instruction decode: a fresh insn this cycle overrides the latched one.
  always_comb begin
    if (cp_irenable_0) begin
      dec_insn_s = cp2_insn;
    end else begin
      dec_insn_s = ir_r;
    end
    rd_s   = dec_insn_s[REG_AW-1:0];
    rs_s   = dec_insn_s[2*REG_AW-1:REG_AW];
    rt_s   = dec_insn_s[3*REG_AW-1:2*REG_AW];
    func_s = dec_insn_s[3*REG_AW+2:3*REG_AW];
  end

  assign unused_dec_s = ^dec_insn_s[31:3*REG_AW+3];

  // Command acceptance and strobe priority ts > as > fs.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && id_en;
    do_ts_s     = accept_s && id_cp2_ts_0;
    do_as_s     = accept_s && id_cp2_as_0 && !id_cp2_ts_0;
    do_fs_s     = accept_s && id_cp2_fs_0 && !id_cp2_ts_0 && !id_cp2_as_0;
    err_s       = accept_s && ((id_cp2_ts_0 && id_cp2_as_0) ||
                               (id_cp2_ts_0 && id_cp2_fs_0) ||
                               (id_cp2_as_0 && id_cp2_fs_0));
    start_mul_s = do_as_s && (func_s == FN_MUL);
  end

  // Single-cycle ALU on the current register file contents.
  always_comb begin
    op_a_s  = regs_r[rs_s];
    op_b_s  = regs_r[rt_s];
    shamt_s = op_b_s[4:0];
    case (func_s)
      FN_ADD:  alu_s = op_a_s + op_b_s;
      FN_SUB:  alu_s = op_a_s - op_b_s;
      FN_AND:  alu_s = op_a_s & op_b_s;
      FN_OR:   alu_s = op_a_s | op_b_s;
      FN_XOR:  alu_s = op_a_s ^ op_b_s;
      FN_SLL:  alu_s = op_a_s << shamt_s;
      FN_SRL:  alu_s = op_a_s >> shamt_s;
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  // MUL sequencer next state and stall request.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_mul_s) begin
          state_next_s = ST_MUL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    if (reset) begin
      cp2_busy = start_mul_s || (state_r == ST_MUL);
    end else begin
      cp2_busy = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Instruction register, only reloaded while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_r <= 32'h0000_0000;
    end else if (cp_irenable_0 && (state_r == ST_IDLE)) begin
      ir_r <= cp2_insn;
    end
  end

  // Shift-add multiplier; operands captured at acceptance so rd may alias rs/rt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      mul_rd_r <= {REG_AW{1'b0}};
    end else if (start_mul_s) begin
      mcand_r  <= op_a_s;
      mplier_r <= op_b_s;
      acc_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      mul_rd_r <= rd_s;
    end else if (state_r == ST_MUL) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {DATA_W{1'b0}});
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Register file writes; ts, ALU and MUL writeback are mutually exclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (do_ts_s) begin
      regs_r[rd_s] <= id_cp2_wr_data;
    end else if (do_as_s && !start_mul_s) begin
      regs_r[rd_s] <= alu_s;
    end else if (state_r == ST_DONE) begin
      regs_r[mul_rd_r] <= acc_r;
    end
  end

  // Registered status and read-data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
      mul_done_r <= 1'b0;
    end else begin
      rd_valid_r <= do_fs_s;
      err_r      <= err_s;
      mul_done_r <= (state_next_s == ST_DONE);
      if (do_fs_s) begin
        rd_data_r <= regs_r[rs_s];
      end
    end
  end

  assign cp2_rd_data  = rd_data_r;
  assign cp2_rd_valid = rd_valid_r;
  assign cp2_mul_done = mul_done_r;
  assign cp2_err      = err_r;

endmodule

// File: tb/tb_cp2_exec.sv
// tb_cp2_exec: directed and random stimulus for cp2_exec against a
// cycle-level behavioural model of the CP2 command semantics.
module tb_cp2_exec;

  logic        clk;
  logic        reset;
  logic        id_en;
  logic        id_cp2_ts_0;
  logic        id_cp2_fs_0;
  logic        id_cp2_as_0;
  logic [31:0] id_cp2_wr_data;
  logic        cp_irenable_0;
  logic [31:0] cp2_insn;
  logic        cp2_busy;
  logic [31:0] cp2_rd_data;
  logic        cp2_rd_valid;
  logic        cp2_mul_done;
  logic        cp2_err;

  cp2_exec dut (
    .clk            (clk),
    .reset          (reset),
    .id_en          (id_en),
    .id_cp2_ts_0    (id_cp2_ts_0),
    .id_cp2_fs_0    (id_cp2_fs_0),
    .id_cp2_as_0    (id_cp2_as_0),
    .id_cp2_wr_data (id_cp2_wr_data),
    .cp_irenable_0  (cp_irenable_0),
    .cp2_insn       (cp2_insn),
    .cp2_busy       (cp2_busy),
    .cp2_rd_data    (cp2_rd_data),
    .cp2_rd_valid   (cp2_rd_valid),
    .cp2_mul_done   (cp2_mul_done),
    .cp2_err        (cp2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_seen;
  int done_seen;

  // Reference model state
  logic [31:0] m_regs [8];
  logic [31:0] m_ir;
  logic [31:0] m_rd_data;
  logic        m_valid;
  logic        m_err;
  int          m_left;   // cycles until MUL writeback; 0 = idle
  int          m_mrd;
  logic [31:0] m_mres;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int rd, input int rs, input int rt, input int fn);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[2:0]  = rd[2:0];
    w[5:3]  = rs[2:0];
    w[8:6]  = rt[2:0];
    w[11:9] = fn[2:0];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
    m_ir = 32'h0; m_rd_data = 32'h0; m_valid = 1'b0; m_err = 1'b0;
    m_left = 0; m_mrd = 0; m_mres = 32'h0;
  endtask

  // One clock cycle: drive, check at negedge against the model, advance model.
  task automatic step(input logic en, input logic ts, input logic fs, input logic as_,
                      input logic [31:0] wd, input logic ire, input logic [31:0] insn);
    logic [31:0] dec, a, b;
    int rd, rs, rt, fn, nstb;
    logic e_busy, e_done, n_valid, n_err;
    id_en = en; id_cp2_ts_0 = ts; id_cp2_fs_0 = fs; id_cp2_as_0 = as_;
    id_cp2_wr_data = wd; cp_irenable_0 = ire; cp2_insn = insn;
    @(negedge clk);
    dec = ire ? insn : m_ir;
    rd = int'(dec[2:0]); rs = int'(dec[5:3]); rt = int'(dec[8:6]); fn = int'(dec[11:9]);
    e_busy = 1'b0; e_done = 1'b0; n_valid = 1'b0; n_err = 1'b0;
    if (m_left == 0) e_busy = en && !ts && as_ && (fn == 2);
    else if (m_left == 1) e_done = 1'b1;
    else e_busy = 1'b1;
    chk("busy", {31'b0, cp2_busy}, {31'b0, e_busy});
    chk("mul_done", {31'b0, cp2_mul_done}, {31'b0, e_done});
    chk("rd_valid", {31'b0, cp2_rd_valid}, {31'b0, m_valid});
    chk("err", {31'b0, cp2_err}, {31'b0, m_err});
    chk("rd_data", cp2_rd_data, m_rd_data);
    if (cp2_busy) busy_seen++;
    if (cp2_mul_done) done_seen++;
    if (m_left != 0) begin
      m_left--;
      if (m_left == 0) m_regs[m_mrd] = m_mres;
    end else begin
      if (en) begin
        nstb = int'(ts) + int'(fs) + int'(as_);
        n_err = (nstb > 1);
        a = m_regs[rs]; b = m_regs[rt];
        if (ts) m_regs[rd] = wd;
        else if (as_) begin
          case (fn)
            0: m_regs[rd] = a + b;
            1: m_regs[rd] = a - b;
            2: begin m_mres = a * b; m_mrd = rd; m_left = 33; end
            3: m_regs[rd] = a & b;
            4: m_regs[rd] = a | b;
            5: m_regs[rd] = a ^ b;
            6: m_regs[rd] = a << b[4:0];
            default: m_regs[rd] = a >> b[4:0];
          endcase
        end else if (fs) begin
          n_valid = 1'b1;
          m_rd_data = m_regs[rs];
        end
      end
      if (ire) m_ir = insn;
    end
    m_valid = n_valid; m_err = n_err;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, cp2_busy}, 32'h0);
    chk({tag, "_valid"}, {31'b0, cp2_rd_valid}, 32'h0);
    chk({tag, "_done"}, {31'b0, cp2_mul_done}, 32'h0);
    chk({tag, "_err"}, {31'b0, cp2_err}, 32'h0);
    chk({tag, "_data"}, cp2_rd_data, 32'h0);
  endtask

  initial begin
    reset = 1'b0; id_en = 1'b0; id_cp2_ts_0 = 1'b0; id_cp2_fs_0 = 1'b0; id_cp2_as_0 = 1'b0;
    id_cp2_wr_data = 32'h0; cp_irenable_0 = 1'b0; cp2_insn = 32'h0;
    model_reset();
    busy_seen = 0; done_seen = 0;
    #2;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // ts then fs of the same register
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, ins(3, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 3, 0, 0));
    chk("t1_fs_data", cp2_rd_data, 32'hDEAD_BEEF);
    chk("t1_fs_valid", {31'b0, cp2_rd_valid}, 32'h1);
    idle();

    // ADD wrap and SUB
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, ins(1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, ins(2, 0, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, ins(4, 1, 2, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, ins(5, 2, 1, 1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 4, 0, 0));
    chk("t2_add_wrap", cp2_rd_data, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 5, 0, 0));
    chk("t2_sub", cp2_rd_data, 32'h0000_0002);
    idle();

    // MUL latency, busy window, ignored commands while busy
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 1'b1, ins(1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0001_0001, 1'b1, ins(2, 0, 0, 0));
    busy_seen = 0; done_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, ins(6, 1, 2, 2));
    for (int k = 0; k < 33; k++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, 1'($urandom_range(0, 1)), $urandom);
    chk("t3_busy_cycles", busy_seen, 32'd33);
    chk("t3_done_pulses", done_seen, 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 6, 0, 0));
    chk("t3_mul_result", cp2_rd_data, 32'h0001_0000);

    // ts+fs collision and id_en=0
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 1'b1, ins(1, 1, 0, 0));
    chk("t4_err", {31'b0, cp2_err}, 32'h1);
    chk("t4_no_valid", {31'b0, cp2_rd_valid}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0009, 1'b1, ins(1, 0, 0, 0));
    chk("t4_no_err", {31'b0, cp2_err}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 1, 0, 0));
    chk("t4_r1", cp2_rd_data, 32'h0000_0005);

    // asynchronous reset in the middle of a MUL
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, ins(6, 1, 2, 2));
    for (int k = 0; k < 10; k++) idle();
    #3;
    reset = 1'b0;
    #1;
    chk_outputs_zero("t5_async");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) idle();
    chk("t5_no_done", done_seen, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 6, 0, 0));
    chk("t5_r6_zero", cp2_rd_data, 32'h0);
    chk("t5_r6_valid", {31'b0, cp2_rd_valid}, 32'h1);

    // latched instruction register
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ins(7, 0, 0, 0));
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 1'b0, ins(2, 2, 2, 2));
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, 7, 0, 0));
    chk("t6_latched_ir", cp2_rd_data, 32'h0000_0077);

    // random traffic against the model
    for (int k = 0; k < 500; k++)
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4),
           $urandom, 1'($urandom_range(0, 1)), $urandom);

    // drain any MUL, then read back every register
    for (int k = 0; k < 40 && m_left != 0; k++) idle();
    for (int r = 0; r < 8; r++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ins(0, r, 0, 0));
      chk("final_reg", cp2_rd_data, m_regs[r]);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
